fsqrt_issue_arbiter: RTL and testbench



---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fsqrt_issue_arbiter_rr_arb2.sv | 44 ++++
 rtl/fsqrt_issue_arbiter.sv | 146 ++++++++++++++
 tb/tb_fsqrt_issue_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU issue-side definitions.
// Holds the arbiter state encoding, common single-precision constants and
// the rounding-mode codes used by the FPU issue arbiters (sqrt, divide).
// No ports: this is a package imported with `import fpu_pkg::*`.
package fpu_pkg;

  // Sequencer states of the shared-unit issue arbiters.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // Single-precision special values.
  localparam logic [31:0] FP32_QNAN = 32'h7fc00000;
  localparam logic [31:0] FP32_PINF = 32'h7f800000;
  localparam logic [31:0] FP32_ZERO = 32'h00000000;

  // Rounding-mode codes as carried on the issue ports.
  localparam logic [1:0] RM_RN = 2'b00;
  localparam logic [1:0] RM_RZ = 2'b01;
  localparam logic [1:0] RM_RP = 2'b10;
  localparam logic [1:0] RM_RM = 2'b11;

  // One-hot grant vector for a two-way arbiter given the winning port id.
  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fsqrt_issue_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a registered last-winner pointer.
// Ports:
//   clock, resetn : clock and synchronous active-low reset
//   req_i[1:0]    : per-port request
//   en_i          : grant allowed this cycle
//   gnt_o[1:0]    : one-hot grant (zero when disabled or nothing requested)
//   gnt_id_o      : index of the port that would win
// The pointer resets to 1 so that port 0 wins the first contended grant.
module rr_arb2
  import fpu_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic lastQ;
  logic prefer;

  assign prefer = ~lastQ;

  // The port that did not win last time has priority; otherwise fall back
  // to the other port.
  always_comb begin
    gnt_id_o = req_i[prefer] ? prefer : lastQ;
    gnt_o    = 2'b00;
    if (en_i && (|req_i)) begin
      gnt_o = onehot2(gnt_id_o);
    end
  end

  // The pointer only moves when a grant is actually issued.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      lastQ <= 1'b1;
    end else if (|gnt_o) begin
      lastQ <= gnt_id_o;
    end
  end

endmodule

// File: rtl/fsqrt_issue_arbiter.sv
// fsqrt_issue_arbiter: shares one iterative square-root unit between the
// integer-pipe FPU issue stage (port 0) and the vector/helper port (port 1).
// One operation is in flight at a time: grant, launch, wait, respond.
// Ports:
//   clock, resetn          : clock, synchronous active-low reset
//   req_valid/req_ready    : per-port request handshake (ready one-hot or 0)
//   req0_d/req0_rm         : port 0 operand and rounding mode
//   req1_d/req1_rm         : port 1 operand and rounding mode
//   u_d/u_rm/u_start       : registered operand, rounding mode, launch pulse
//   u_busy/u_done/u_s      : unit status, result-valid pulse and result
//   resp_valid/resp_id/resp_s/resp_err/resp_ready : result handshake
//   stall                  : per-port req_valid & ~req_ready
module fsqrt_issue_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 40,
  parameter logic [31:0] NAN_PATTERN = FP32_QNAN
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_d,
  input  logic [1:0]  req0_rm,
  input  logic [31:0] req1_d,
  input  logic [1:0]  req1_rm,
  output logic [31:0] u_d,
  output logic [1:0]  u_rm,
  output logic        u_start,
  input  logic        u_busy,
  input  logic        u_done,
  input  logic [31:0] u_s,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_s,
  output logic        resp_err,
  input  logic        resp_ready,
  output logic [1:0]  stall
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e       state_q;
  logic             owner_q;
  logic [31:0]      u_d_q;
  logic [1:0]       u_rm_q;
  logic             u_start_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [31:0]      resp_s_q;
  logic             resp_err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeoutHit;
  logic             arbEn;
  logic             gntId;

  // Grants are only possible in IDLE with the unit free; holding reset
  // also masks them so ready reads zero while resetn is low.
  assign arbEn = resetn && (state_q == ST_IDLE) && !u_busy;

  rr_arb2 u_arb (
    .clock    (clock),
    .resetn   (resetn),
    .req_i    (req_valid),
    .en_i     (arbEn),
    .gnt_o    (req_ready),
    .gnt_id_o (gntId)
  );

  assign stall = req_valid & ~req_ready;

  // Saturating watchdog count. The abort fires when the incremented value
  // reaches TIMEOUT_CYC-1, which puts resp_valid exactly TIMEOUT_CYC
  // cycles after the u_start cycle.
  assign cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeoutHit = (cnt_d >= TO_LAST);

  // Sequencer with all unit-side and response outputs registered.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      u_d_q        <= '0;
      u_rm_q       <= '0;
      u_start_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_s_q     <= '0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      u_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req_ready) begin
            u_d_q     <= gntId ? req1_d : req0_d;
            u_rm_q    <= gntId ? req1_rm : req0_rm;
            owner_q   <= gntId;
            u_start_q <= 1'b1;
            state_q   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          // A real result beats the watchdog when both land together.
          if (u_done) begin
            resp_s_q     <= u_s;
            resp_err_q   <= 1'b0;
            resp_id_q    <= owner_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (timeoutHit) begin
            resp_s_q     <= NAN_PATTERN;
            resp_err_q   <= 1'b1;
            resp_id_q    <= owner_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign u_d        = u_d_q;
  assign u_rm       = u_rm_q;
  assign u_start    = u_start_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_s     = resp_s_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_fsqrt_issue_arbiter.sv
// Self-checking bench for fsqrt_issue_arbiter. Directed requests push their
// hand-computed responses into a scoreboard queue; a monitor process checks
// every presented response against the queue head and pops on handshake.
// A small behavioural sqrt unit answers launches after a set delay.
module tb_fsqrt_issue_arbiter;
  import fpu_pkg::*;

  localparam int TIMEOUT = 40;

  localparam logic [31:0] F_1  = 32'h3f800000;
  localparam logic [31:0] F_2  = 32'h40000000;
  localparam logic [31:0] F_3  = 32'h40400000;
  localparam logic [31:0] F_4  = 32'h40800000;
  localparam logic [31:0] F_9  = 32'h41100000;
  localparam logic [31:0] F_16 = 32'h41800000;

  localparam logic        CONT_PORT [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [31:0] CONT_D    [3] = '{F_4, F_9, F_16};
  localparam logic [1:0]  CONT_RM   [3] = '{RM_RN, RM_RZ, RM_RN};
  localparam logic [31:0] CONT_S    [3] = '{F_2, F_3, F_4};

  typedef struct packed {
    logic        id;
    logic [31:0] s;
    logic        err;
  } exp_t;

  logic        clock;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_d;
  logic [1:0]  req0_rm;
  logic [31:0] req1_d;
  logic [1:0]  req1_rm;
  logic [31:0] u_d;
  logic [1:0]  u_rm;
  logic        u_start;
  logic        u_busy;
  logic        u_done;
  logic [31:0] u_s;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_s;
  logic        resp_err;
  logic        resp_ready;
  logic [1:0]  stall;

  logic        modelBusy;
  logic        modelDone;
  logic [31:0] modelS;
  logic        forceBusy;
  logic        lateDone;
  logic [31:0] lateS;
  bit          unitMute;
  int          unitDelay;

  int   checks = 0;
  int   failures = 0;
  exp_t sbQ[$];

  assign u_busy = modelBusy | forceBusy;
  assign u_done = modelDone | lateDone;
  assign u_s    = lateDone ? lateS : modelS;

  fsqrt_issue_arbiter #(
    .TIMEOUT_CYC (TIMEOUT),
    .NAN_PATTERN (32'h7fc00000)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_d     (req0_d),
    .req0_rm    (req0_rm),
    .req1_d     (req1_d),
    .req1_rm    (req1_rm),
    .u_d        (u_d),
    .u_rm       (u_rm),
    .u_start    (u_start),
    .u_busy     (u_busy),
    .u_done     (u_done),
    .u_s        (u_s),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_s     (resp_s),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .stall      (stall)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

  // Hand-computed square roots of the operands used below.
  function automatic logic [31:0] sqrtRef(input logic [31:0] d);
    case (d)
      F_1:     return F_1;
      F_4:     return F_2;
      F_9:     return F_3;
      F_16:    return F_4;
      default: return 32'hdeadbeef;
    endcase
  endfunction

  // Behavioural unit: answers a launch after unitDelay cycles unless muted
  // or reset while iterating.
  initial begin
    logic [31:0] res;
    bit aborted;
    modelBusy = 1'b0;
    modelDone = 1'b0;
    modelS    = '0;
    forever begin
      @(posedge clock);
      #1;
      if (resetn === 1'b1 && u_start === 1'b1 && !unitMute) begin
        res       = sqrtRef(u_d);
        modelBusy = 1'b1;
        aborted   = 1'b0;
        for (int i = 0; i < unitDelay; i++) begin
          @(posedge clock);
          if (resetn !== 1'b1) aborted = 1'b1;
          #1;
          if (aborted) break;
        end
        modelBusy = 1'b0;
        if (!aborted) begin
          modelDone = 1'b1;
          modelS    = res;
          @(posedge clock);
          #1;
          modelDone = 1'b0;
        end
      end
    end
  end

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endfunction

  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] d0,
                               input logic [1:0] rm0, input logic [31:0] d1,
                               input logic [1:0] rm1);
    req_valid = valid;
    req0_d    = d0;
    req0_rm   = rm0;
    req1_d    = d1;
    req1_rm   = rm1;
  endtask

  task automatic pushExp(input logic id, input logic [31:0] s, input logic err);
    exp_t e;
    e.id  = id;
    e.s   = s;
    e.err = err;
    sbQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic waitGrant(input string name, input logic [1:0] required);
    int n;
    n = 0;
    @(negedge clock);
    while (req_ready === 2'b00 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(req_ready), 32'(required));
  endtask

  task automatic waitResp(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (resp_valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(resp_valid), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while ((sbQ.size() != 0 || resp_valid !== 1'b0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(sbQ.size()), 32'd0);
  endtask

  // Response monitor: every cycle a response is presented it must match the
  // scoreboard head; the head retires on handshake.
  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && resp_valid !== 1'b0) begin
        if (sbQ.size() == 0) begin
          checkOutput("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          e = sbQ[0];
          checkOutput("resp_id", 32'(resp_id), 32'(e.id));
          checkOutput("resp_s", resp_s, e.s);
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
          if (resp_ready === 1'b1) void'(sbQ.pop_front());
        end
      end
    end
  endtask

  initial begin
    int n;
    resetn     = 1'b0;
    resp_ready = 1'b1;
    forceBusy  = 1'b0;
    lateDone   = 1'b0;
    lateS      = '0;
    unitMute   = 1'b0;
    unitDelay  = 4;
    applyStimulus(2'b11, F_4, RM_RN, F_9, RM_RZ);
    fork
      monitorLoop();
    join_none

    // Reset values with both ports already requesting.
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd3);
    checkOutput("rst_u_start", 32'(u_start), 32'd0);
    checkOutput("rst_u_d", u_d, 32'd0);
    checkOutput("rst_u_rm", 32'(u_rm), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
    checkOutput("rst_resp_s", resp_s, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    tick();
    resetn = 1'b1;

    // Contention: grants 0, 1, 0.
    for (int g = 0; g < 3; g++) begin
      waitGrant("cont_grant", onehot2(CONT_PORT[g]));
      pushExp(CONT_PORT[g], CONT_S[g], 1'b0);
      tick();
      if (g == 0) req_valid = 2'b10;
      if (g == 1) req1_d = F_1;
      if (g == 2) req_valid = 2'b00;
      @(negedge clock);
      checkOutput("cont_u_start", 32'(u_start), 32'd1);
      checkOutput("cont_u_d", u_d, CONT_D[g]);
      checkOutput("cont_u_rm", 32'(u_rm), 32'(CONT_RM[g]));
      checkOutput("cont_ready_launch", 32'(req_ready), 32'd0);
      if (g == 0) begin
        checkOutput("cont_stall", 32'(stall), 32'd2);
        tick();
        req_valid = 2'b11;
        req0_d    = F_16;
      end
    end
    drain("cont_drain");

    // Single request on port 0 with a 26-cycle unit.
    unitDelay = 26;
    tick();
    applyStimulus(2'b01, F_4, RM_RN, F_9, RM_RZ);
    @(negedge clock);
    checkOutput("single_ready", 32'(req_ready), 32'd1);
    checkOutput("single_stall", 32'(stall), 32'd0);
    pushExp(1'b0, F_2, 1'b0);
    tick();
    req_valid = 2'b00;
    @(negedge clock);
    checkOutput("single_u_start", 32'(u_start), 32'd1);
    checkOutput("single_u_d", u_d, F_4);
    checkOutput("single_u_rm", 32'(u_rm), 32'(RM_RN));
    @(negedge clock);
    checkOutput("single_start_pulse", 32'(u_start), 32'd0);
    drain("single_drain");

    // Backpressure: response held 5 cycles while port 0 waits.
    unitDelay = 6;
    tick();
    resp_ready = 1'b0;
    applyStimulus(2'b10, F_4, RM_RN, F_1, RM_RM);
    @(negedge clock);
    checkOutput("bp_grant", 32'(req_ready), 32'd2);
    pushExp(1'b1, F_1, 1'b0);
    tick();
    applyStimulus(2'b01, F_16, RM_RP, F_1, RM_RM);
    waitResp("bp_resp");
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_no_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_stall", 32'(stall), 32'd1);
      @(negedge clock);
    end
    tick();
    resp_ready = 1'b1;
    pushExp(1'b0, F_4, 1'b0);
    @(negedge clock);
    checkOutput("bp_turnaround", 32'(req_ready), 32'd0);
    @(negedge clock);
    checkOutput("bp_next_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    drain("bp_drain");

    // Timeout: unit never answers.
    unitMute = 1'b1;
    tick();
    applyStimulus(2'b10, F_4, RM_RN, F_9, RM_RZ);
    @(negedge clock);
    checkOutput("to_grant", 32'(req_ready), 32'd2);
    pushExp(1'b1, 32'h7fc00000, 1'b1);
    tick();
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    @(negedge clock);
    checkOutput("to_u_start", 32'(u_start), 32'd1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (resp_valid !== 1'b1 && n < 60);
    checkOutput("to_latency", 32'(n), 32'(TIMEOUT));
    tick();
    lateDone = 1'b1;
    lateS    = F_1;
    tick();
    lateDone = 1'b0;
    @(negedge clock);
    checkOutput("to_late_done_s", resp_s, 32'h7fc00000);
    checkOutput("to_late_done_err", 32'(resp_err), 32'd1);
    tick();
    resp_ready = 1'b1;
    drain("to_drain");
    tick();
    lateDone = 1'b1;
    tick();
    lateDone = 1'b0;
    @(negedge clock);
    checkOutput("idle_stray_done", 32'(resp_valid), 32'd0);
    unitMute = 1'b0;

    // Busy block: request waits while the unit reports busy.
    unitDelay = 3;
    forceBusy = 1'b1;
    tick();
    applyStimulus(2'b10, F_4, RM_RN, F_1, RM_RM);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("busy_no_ready", 32'(req_ready), 32'd0);
      checkOutput("busy_stall", 32'(stall), 32'd2);
    end
    tick();
    forceBusy = 1'b0;
    @(negedge clock);
    checkOutput("busy_grant", 32'(req_ready), 32'd2);
    pushExp(1'b1, F_1, 1'b0);
    tick();
    req_valid = 2'b00;
    drain("busy_drain");

    // Reset in the middle of WAIT.
    unitDelay = 20;
    tick();
    applyStimulus(2'b01, F_16, RM_RP, F_9, RM_RZ);
    @(negedge clock);
    checkOutput("mid_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clock);
    checkOutput("mid_rst_u_start", 32'(u_start), 32'd0);
    checkOutput("mid_rst_u_d", u_d, 32'd0);
    checkOutput("mid_rst_u_rm", 32'(u_rm), 32'd0);
    checkOutput("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("mid_rst_resp_id", 32'(resp_id), 32'd0);
    checkOutput("mid_rst_resp_s", resp_s, 32'd0);
    checkOutput("mid_rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    n = 0;
    repeat (30) begin
      @(negedge clock);
      if (u_start === 1'b1) n++;
    end
    checkOutput("mid_rst_no_launch", 32'(n), 32'd0);

    // Clean transaction after reset; pointer back to port-0-first.
    unitDelay = 5;
    tick();
    applyStimulus(2'b11, F_16, RM_RN, F_9, RM_RZ);
    @(negedge clock);
    checkOutput("post_rst_grant", 32'(req_ready), 32'd1);
    pushExp(1'b0, F_4, 1'b0);
    tick();
    req_valid = 2'b00;
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
